pipeline_sequencer: RTL and testbench

Parametrised pipeline sequencing controller for the ARM32 pipelined core. It tracks a valid bit and PC tag through NUM_STAGES stages, applies stall (hold plus bubble), branch flush and halt drain, and generates PC-register control (load_pc, sel_pc). It runs a start/run/drain/halted state machine that supports restart from HALTED without a reset. It sits beside the existing stage units and replaces the fixed 7-stage valid/branch bookkeeping with a generic one.

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/pipe_stage_tag.sv | 26 ++
 rtl/pipeline_sequencer.sv | 80 ++++++++
 tb/tb_pipeline_sequencer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding, PC-select codes and default sizes for the pipeline sequencer.
package pipeline_ctrl_pkg;
   typedef enum logic [1:0] {
      LOAD   = 2'b00,
      RUN    = 2'b01,
      DRAIN  = 2'b10,
      HALTED = 2'b11
   } seq_state_t;
   localparam logic [1:0] SEL_PC_INC    = 2'b00;
   localparam logic [1:0] SEL_PC_START  = 2'b01;
   localparam logic [1:0] SEL_PC_BRANCH = 2'b10;
   localparam int DEF_PC_W       = 7;
   localparam int DEF_NUM_STAGES = 7;
endpackage

// File: rtl/pipe_stage_tag.sv
// pipe_stage_tag: one pipeline stage's valid bit and PC tag.
module pipe_stage_tag #(
   parameter int PC_W = 7
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            hold,
   input  logic            bubble,
   input  logic            kill,
   input  logic            d_valid,
   input  logic [PC_W-1:0] d_pc,
   output logic            valid,
   output logic [PC_W-1:0] pc
);
   // kill and bubble only drop the valid bit; the tag is left as it was
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         valid <= 1'b0;
         pc    <= '0;
      end else if (kill || bubble)
         valid <= 1'b0;
      else if (!hold) begin
         valid <= d_valid;
         pc    <= d_pc;
      end
endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: generic valid/PC-tag bookkeeping with stall, flush and halt drain,
// plus the LOAD/RUN/DRAIN/HALTED sequencer and PC-register control.
module pipeline_sequencer
   import pipeline_ctrl_pkg::*;
#(
   parameter int PC_W          = DEF_PC_W,
   parameter int NUM_STAGES    = DEF_NUM_STAGES,
   parameter int STALL_STAGE   = 3,
   parameter int RESOLVE_STAGE = 4,
   parameter int CNT_W         = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [PC_W-1:0]            start_pc,
   input  logic [PC_W-1:0]            pc_in,
   input  logic                       stall_req,
   input  logic                       branch_taken,
   input  logic                       halt_detect,
   output logic [NUM_STAGES-1:0]      stage_valid,
   output logic [NUM_STAGES*PC_W-1:0] stage_pc,
   output logic                       load_pc,
   output logic [1:0]                 sel_pc,
   output logic [PC_W-1:0]            halt_pc,
   output logic [1:0]                 state,
   output logic                       halted,
   output logic [CNT_W-1:0]           retired_count
);
   seq_state_t st, nxt;
   logic run, res_v, br, hl, stl, fetch, drained;
   assign run     = st == RUN;
   assign res_v   = stage_valid[RESOLVE_STAGE];
   assign br      = branch_taken & res_v;
   assign hl      = halt_detect & res_v;
   assign stl     = stall_req & stage_valid[STALL_STAGE] & ~br & ~hl;
   assign fetch   = run & ~stl & ~br & ~hl;
   assign drained = ~|stage_valid[NUM_STAGES-1:RESOLVE_STAGE+1];
   // a halt overrides a same-cycle branch, so the PC register is never redirected
   assign load_pc = (st == LOAD) | (run & ~hl & (br | ~stl));
   assign sel_pc  = (st == LOAD) ? SEL_PC_START : (run & br & ~hl) ? SEL_PC_BRANCH : SEL_PC_INC;
   assign state   = st;
   assign halted  = st == HALTED;
   for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
      logic            dv;
      logic [PC_W-1:0] dp;
      if (i == 0) begin : g_head
         assign dv = fetch;
         assign dp = fetch ? pc_in : stage_pc[PC_W-1:0];
      end else begin : g_body
         assign dv = stage_valid[i-1];
         assign dp = stage_pc[(i-1)*PC_W +: PC_W];
      end
      pipe_stage_tag #(.PC_W(PC_W)) u_tag (
         .clk    (clk),
         .rst_n  (rst_n),
         .hold   (stl & (i <= STALL_STAGE)),
         .bubble (stl & (i == STALL_STAGE + 1)),
         .kill   ((br | hl) & (i <= RESOLVE_STAGE)),
         .d_valid(dv),
         .d_pc   (dp),
         .valid  (stage_valid[i]),
         .pc     (stage_pc[i*PC_W +: PC_W])
      );
   end
   always_comb
      nxt = (st == LOAD) ? RUN :
            (run & hl) ? DRAIN :
            (st == DRAIN & drained) ? HALTED :
            (st == HALTED & start) ? LOAD : st;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st            <= LOAD;
         halt_pc       <= '0;
         retired_count <= '0;
      end else begin
         st            <= nxt;
         if (run & hl) halt_pc <= stage_pc[RESOLVE_STAGE*PC_W +: PC_W];
         retired_count <= retired_count + CNT_W'(stage_valid[NUM_STAGES-1]);
      end
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: table-driven directed check of sequencing, stall, flush, halt drain and async reset.
module tb_pipeline_sequencer;
   localparam int PC_W = 7, NS = 7, CNT_W = 32;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic stall_req = 1'b0, branch_taken = 1'b0, halt_detect = 1'b0;
   logic [PC_W-1:0] start_pc = 7'd5, pc_in = '0;
   logic [NS-1:0] stage_valid;
   logic [NS*PC_W-1:0] stage_pc;
   logic load_pc, halted;
   logic [1:0] sel_pc, state;
   logic [PC_W-1:0] halt_pc;
   logic [CNT_W-1:0] retired_count;
   pipeline_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .pc_in(pc_in),
      .stall_req(stall_req), .branch_taken(branch_taken), .halt_detect(halt_detect),
      .stage_valid(stage_valid), .stage_pc(stage_pc), .load_pc(load_pc), .sel_pc(sel_pc),
      .halt_pc(halt_pc), .state(state), .halted(halted), .retired_count(retired_count)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic stall, br, hl, st;
      logic [6:0] pc;
      logic load;
      logic [1:0] sel;
      logic [6:0] valid;
      logic [1:0] state;
      int pidx;
      logic [6:0] ppc;
      logic [31:0] cnt;
      logic [6:0] hpc;
   } vec_t;
   vec_t tbl[$];
   int total = 0, bad = 0;
   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
      end
   endtask
   task automatic add(input logic stall, br, hl, st, input logic [6:0] pc, input logic load,
                      input logic [1:0] sel, input logic [6:0] valid, input logic [1:0] stt,
                      input int pidx, input logic [6:0] ppc, input logic [31:0] cnt, input logic [6:0] hpc);
      vec_t v;
      v = '{stall, br, hl, st, pc, load, sel, valid, stt, pidx, ppc, cnt, hpc};
      tbl.push_back(v);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      // stall br hl st  pc  load sel valid      state pidx ppc cnt hpc
      add(0,0,0,0,  0, 1,2'd1, 7'b0000000, 2'd1, 7, 0, 0, 0);
      add(0,0,0,0,  5, 1,2'd0, 7'b0000001, 2'd1, 0, 5, 0, 0);
      add(0,0,0,0,  6, 1,2'd0, 7'b0000011, 2'd1, 1, 5, 0, 0);
      add(0,0,0,0,  7, 1,2'd0, 7'b0000111, 2'd1, 2, 5, 0, 0);
      add(0,0,0,0,  8, 1,2'd0, 7'b0001111, 2'd1, 3, 5, 0, 0);
      add(0,0,0,0,  9, 1,2'd0, 7'b0011111, 2'd1, 4, 5, 0, 0);
      add(0,0,0,0, 10, 1,2'd0, 7'b0111111, 2'd1, 5, 5, 0, 0);
      add(0,0,0,0, 11, 1,2'd0, 7'b1111111, 2'd1, 6, 5, 0, 0);
      add(1,0,0,0, 12, 0,2'd0, 7'b1101111, 2'd1, 3, 8, 1, 0);
      add(1,0,0,0, 12, 0,2'd0, 7'b1001111, 2'd1, 0,11, 2, 0);
      add(0,0,0,0, 12, 1,2'd0, 7'b0011111, 2'd1, 4, 8, 3, 0);
      add(0,0,0,0, 13, 1,2'd0, 7'b0111111, 2'd1, 5, 8, 3, 0);
      add(0,1,0,0, 14, 1,2'd2, 7'b1100000, 2'd1, 5, 9, 3, 0);
      add(0,0,0,0, 40, 1,2'd0, 7'b1000001, 2'd1, 0,40, 4, 0);
      add(0,0,0,0, 41, 1,2'd0, 7'b0000011, 2'd1, 1,40, 5, 0);
      add(1,0,0,0, 42, 1,2'd0, 7'b0000111, 2'd1, 7, 0, 5, 0);
      add(0,0,0,0, 43, 1,2'd0, 7'b0001111, 2'd1, 3,40, 5, 0);
      add(0,0,0,0, 44, 1,2'd0, 7'b0011111, 2'd1, 4,40, 5, 0);
      add(1,1,0,0, 45, 1,2'd2, 7'b0100000, 2'd1, 5,40, 5, 0);
      add(0,0,0,0, 60, 1,2'd0, 7'b1000001, 2'd1, 6,40, 5, 0);
      add(0,1,0,0, 61, 1,2'd0, 7'b0000011, 2'd1, 1,60, 6, 0);
      add(0,0,0,0, 62, 1,2'd0, 7'b0000111, 2'd1, 7, 0, 6, 0);
      add(0,0,0,0, 63, 1,2'd0, 7'b0001111, 2'd1, 7, 0, 6, 0);
      add(0,0,0,0, 64, 1,2'd0, 7'b0011111, 2'd1, 4,60, 6, 0);
      add(0,1,1,0, 65, 0,2'd0, 7'b0100000, 2'd2, 5,60, 6,60);
      add(0,0,0,1,  0, 0,2'd0, 7'b1000000, 2'd2, 6,60, 6,60);
      add(0,0,0,0,  0, 0,2'd0, 7'b0000000, 2'd2, 7, 0, 7,60);
      add(0,0,0,0,  0, 0,2'd0, 7'b0000000, 2'd3, 7, 0, 7,60);
      add(0,0,0,0,  0, 0,2'd0, 7'b0000000, 2'd3, 7, 0, 7,60);
      add(0,0,0,1,  0, 0,2'd0, 7'b0000000, 2'd0, 7, 0, 7,60);
      add(0,0,0,0,  0, 1,2'd1, 7'b0000000, 2'd1, 7, 0, 7,60);
      add(0,0,0,0,  0, 1,2'd0, 7'b0000001, 2'd1, 0, 0, 7,60);
      add(0,0,0,0,  1, 1,2'd0, 7'b0000011, 2'd1, 0, 1, 7,60);
      add(0,0,0,0,  2, 1,2'd0, 7'b0000111, 2'd1, 7, 0, 7,60);
      add(0,0,0,0,  3, 1,2'd0, 7'b0001111, 2'd1, 7, 0, 7,60);
      add(0,0,0,0,  4, 1,2'd0, 7'b0011111, 2'd1, 4, 0, 7,60);
      add(0,0,1,0,  5, 0,2'd0, 7'b0100000, 2'd2, 5, 0, 7, 0);
      #2;
      chk("rst_state", -1, state, 0);
      chk("rst_valid", -1, stage_valid, 0);
      chk("rst_pc", -1, stage_pc[31:0], 0);
      chk("rst_cnt", -1, retired_count, 0);
      chk("rst_halted", -1, halted, 0);
      chk("rst_halt_pc", -1, halt_pc, 0);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         if (i > 0) @(negedge clk);
         stall_req = tbl[i].stall;
         branch_taken = tbl[i].br;
         halt_detect = tbl[i].hl;
         start = tbl[i].st;
         pc_in = tbl[i].pc;
         #1;
         chk("load_pc", i, load_pc, tbl[i].load);
         chk("sel_pc", i, sel_pc, tbl[i].sel);
         @(posedge clk);
         #1;
         chk("valid", i, stage_valid, tbl[i].valid);
         chk("state", i, state, tbl[i].state);
         chk("halted", i, halted, tbl[i].state == 2'd3);
         chk("retired", i, retired_count, tbl[i].cnt);
         chk("halt_pc", i, halt_pc, tbl[i].hpc);
         if (tbl[i].pidx < NS)
            chk("stage_pc", i, stage_pc[tbl[i].pidx*PC_W +: PC_W], tbl[i].ppc);
      end
      stall_req = 1'b0;
      branch_taken = 1'b0;
      halt_detect = 1'b0;
      start = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", 100, stage_valid, 0);
      chk("async_state", 100, state, 0);
      chk("async_cnt", 100, retired_count, 0);
      chk("async_halt_pc", 100, halt_pc, 0);
      chk("async_halted", 100, halted, 0);
      @(negedge clk) rst_n = 1'b1;
      #1;
      chk("post_rst_load", 101, load_pc, 1);
      chk("post_rst_sel", 101, sel_pc, 1);
      @(posedge clk);
      #1;
      chk("post_rst_state", 101, state, 1);
      chk("post_rst_valid", 101, stage_valid, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
